// File: rtl/sipo_shift_controller.sv
// Framed serial-in/parallel-out sequencer: start strobe, WIDTH bits MSB-first,
// optional even-parity bit, then the word is held on a valid/ready handshake.
module sipo_shift_controller #(
    parameter int WIDTH     = 3,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             si,
    output logic             busy,
    output logic             shift_en,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] po_r;
    logic             parity_err_r;
    logic             overrun_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Frame sequencer: state, shift register, held word and status flags
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r      <= IDLE;
            bit_cnt_r    <= '0;
            sreg_r       <= '0;
            po_r         <= '0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= SHIFT;
                        bit_cnt_r <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    sreg_r    <= {sreg_r[WIDTH-2:0], si};
                    bit_cnt_r <= bit_cnt_r + CW'(1);
                    if (bit_cnt_r == CW'(WIDTH - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_r <= PARITY;
                        end else begin
                            // No parity phase: the word goes straight to HOLD
                            state_r      <= HOLD;
                            po_r         <= {sreg_r[WIDTH-2:0], si};
                            parity_err_r <= 1'b0;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                PARITY: begin
                    parity_err_r <= even_parity(sreg_r) ^ si;
                    po_r         <= sreg_r;
                    state_r      <= HOLD;
                end
                HOLD: begin
                    if (po_ready) begin
                        if (start) begin
                            state_r   <= SHIFT;
                            bit_cnt_r <= '0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (start) begin
                        // Consumer has not taken the held word; drop the request
                        overrun_r <= 1'b1;
                        state_r   <= HOLD;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_r == SHIFT) || (state_r == PARITY);
    assign shift_en   = (state_r == SHIFT);
    assign po_valid   = (state_r == HOLD);
    assign po         = po_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_sipo_shift_controller.sv
// Scoreboard bench for sipo_shift_controller: one instance without parity
// (index 0) and one with parity (index 1), driven and sampled on falling edges.
module tb_sipo_shift_controller;

    typedef struct packed {
        logic [2:0] po;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [1:0] start_v = 2'b00;
    logic [1:0] si_v = 2'b00;
    logic [1:0] ready_v = 2'b00;
    logic [1:0] busy_v;
    logic [1:0] shift_en_v;
    logic [1:0] po_valid_v;
    logic [1:0] perr_v;
    logic [1:0] ovr_v;
    logic [2:0] po_v [2];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sipo_shift_controller #(.WIDTH(3), .PARITY_EN(0)) dut0 (
        .clk(clk), .clear(clear), .start(start_v[0]), .si(si_v[0]),
        .busy(busy_v[0]), .shift_en(shift_en_v[0]), .po(po_v[0]),
        .po_valid(po_valid_v[0]), .po_ready(ready_v[0]),
        .parity_err(perr_v[0]), .overrun(ovr_v[0])
    );

    sipo_shift_controller #(.WIDTH(3), .PARITY_EN(1)) dut1 (
        .clk(clk), .clear(clear), .start(start_v[1]), .si(si_v[1]),
        .busy(busy_v[1]), .shift_en(shift_en_v[1]), .po(po_v[1]),
        .po_valid(po_valid_v[1]), .po_ready(ready_v[1]),
        .parity_err(perr_v[1]), .overrun(ovr_v[1])
    );

    // Runs one frame starting at a falling edge; pushes the expected word and
    // pops/compares it once po_valid shows up.
    task automatic shift_frame(input int d, input logic [2:0] bits, input logic pbit, input logic b2b);
        int   waited;
        exp_t e;
        exp_t got;
        e.po   = bits;
        e.perr = (d == 1) ? (^bits ^ pbit) : 1'b0;
        sb.push_back(e);
        start_v[d] = 1'b1;
        ready_v[d] = b2b;
        @(negedge clk);
        start_v[d] = 1'b0;
        ready_v[d] = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            checks++;
            if ({busy_v[d], shift_en_v[d], po_valid_v[d]} !== 3'b110) begin
                errors++;
                $display("FAIL shift_phase dut%0d bit%0d: busy/shift_en/po_valid=%b expected 110",
                         d, i, {busy_v[d], shift_en_v[d], po_valid_v[d]});
            end
            si_v[d] = bits[i];
            @(negedge clk);
        end
        if (d == 1) begin
            checks++;
            if ({busy_v[d], shift_en_v[d], po_valid_v[d]} !== 3'b100) begin
                errors++;
                $display("FAIL parity_phase dut%0d: busy/shift_en/po_valid=%b expected 100",
                         d, {busy_v[d], shift_en_v[d], po_valid_v[d]});
            end
            si_v[d] = pbit;
            @(negedge clk);
        end
        si_v[d] = 1'b0;
        waited = 0;
        while (po_valid_v[d] !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited != 0) begin
            errors++;
            $display("FAIL valid_latency dut%0d: po_valid after %0d extra cycles, expected 0", d, waited);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard dut%0d: output word with empty queue", d);
        end else begin
            got = sb.pop_front();
            if ({po_v[d], perr_v[d], busy_v[d]} !== {got.po, got.perr, 1'b0}) begin
                errors++;
                $display("FAIL word dut%0d: po=%b perr=%b busy=%b expected po=%b perr=%b busy=0",
                         d, po_v[d], perr_v[d], busy_v[d], got.po, got.perr);
            end
        end
    endtask

    task automatic consume(input int d, input logic [2:0] last_po);
        ready_v[d] = 1'b1;
        @(negedge clk);
        ready_v[d] = 1'b0;
        checks++;
        if ({po_valid_v[d], busy_v[d], po_v[d]} !== {1'b0, 1'b0, last_po}) begin
            errors++;
            $display("FAIL consume dut%0d: po_valid=%b busy=%b po=%b expected 0 0 %b",
                     d, po_valid_v[d], busy_v[d], po_v[d], last_po);
        end
    endtask

    task automatic test_reset();
        clear   = 1'b1;
        start_v = 2'b11;
        si_v    = 2'b11;
        ready_v = 2'b11;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_v[d], shift_en_v[d], po_valid_v[d], perr_v[d], ovr_v[d], po_v[d]} !== 8'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: busy,shift_en,valid,perr,ovr,po=%b expected 0",
                         d, {busy_v[d], shift_en_v[d], po_valid_v[d], perr_v[d], ovr_v[d], po_v[d]});
            end
        end
        start_v = 2'b00;
        si_v    = 2'b00;
        ready_v = 2'b00;
        @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_v[d], po_valid_v[d]} !== 2'b00) begin
                errors++;
                $display("FAIL reset_release dut%0d: busy/po_valid=%b expected 00", d, {busy_v[d], po_valid_v[d]});
            end
        end
    endtask

    task automatic test_no_parity();
        shift_frame(0, 3'b101, 1'b0, 1'b0);
        consume(0, 3'b101);
        shift_frame(0, 3'b010, 1'b0, 1'b0);
        consume(0, 3'b010);
    endtask

    task automatic test_parity();
        shift_frame(1, 3'b110, 1'b0, 1'b0);
        consume(1, 3'b110);
        shift_frame(1, 3'b110, 1'b1, 1'b0);
        consume(1, 3'b110);
        shift_frame(1, 3'b100, 1'b0, 1'b0);
        consume(1, 3'b100);
    endtask

    task automatic test_overrun();
        shift_frame(1, 3'b011, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            start_v[1] = (k == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if ({po_valid_v[1], busy_v[1], po_v[1], ovr_v[1]} !== {1'b1, 1'b0, 3'b011, (k == 1) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL overrun cycle%0d: valid=%b busy=%b po=%b overrun=%b expected 1 0 011 %b",
                         k, po_valid_v[1], busy_v[1], po_v[1], ovr_v[1], (k == 1) ? 1'b1 : 1'b0);
            end
        end
        start_v[1] = 1'b0;
        consume(1, 3'b011);
    endtask

    task automatic test_back_to_back();
        shift_frame(1, 3'b101, 1'b0, 1'b0);
        shift_frame(1, 3'b010, 1'b1, 1'b1);
        consume(1, 3'b010);
        shift_frame(0, 3'b001, 1'b0, 1'b0);
        shift_frame(0, 3'b110, 1'b0, 1'b1);
        consume(0, 3'b110);
    endtask

    task automatic test_clear_mid();
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        si_v[0]    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        #1;
        checks++;
        if ({busy_v[0], shift_en_v[0], po_valid_v[0]} !== 3'b000) begin
            errors++;
            $display("FAIL clear_mid: busy/shift_en/po_valid=%b expected 000",
                     {busy_v[0], shift_en_v[0], po_valid_v[0]});
        end
        @(negedge clk);
        clear   = 1'b0;
        si_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({po_valid_v[0], busy_v[0]} !== 2'b00) begin
                errors++;
                $display("FAIL clear_after cycle%0d: po_valid/busy=%b expected 00", k, {po_valid_v[0], busy_v[0]});
            end
        end
        shift_frame(0, 3'b111, 1'b0, 1'b0);
        consume(0, 3'b111);
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_overrun();
        test_back_to_back();
        test_clear_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_shift_controller.md
Name: sipo_shift_controller

Overview:
Sequencer for a serial-in/parallel-out shift datapath.
- Accepts a start strobe, then shifts exactly WIDTH serial bits MSB-first.
- Optionally samples an even-parity bit after the data bits.
- Presents the assembled word on a valid/ready output handshake.
- Sits between a serial link front-end and parallel consumer logic, replacing free-running shift registers that have no framing.

Parameters:
WIDTH, 3, number of data bits per frame (>=2)
PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity phase

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous, active-high reset
start  input  1  frame start request; accepted only in IDLE, or in HOLD together with po_ready
si  input  1  serial data in
busy  output  1  high in SHIFT and PARITY
shift_en  output  1  high on every cycle in which si is captured as a data bit
po  output  WIDTH  assembled word; first-received bit in po[WIDTH-1]
po_valid  output  1  word available (HOLD state)
po_ready  input  1  consumer accepts word
parity_err  output  1  valid with po_valid; 1 = parity mismatch (always 0 when PARITY_EN=0)
overrun  output  1  one-cycle pulse when start arrives while a word is held and not consumed

Behaviour:
- Reset (clear=1, asynchronous):
  - state=IDLE, bit_cnt=0, shift register=0.
  - po=0, po_valid=0, busy=0, shift_en=0, parity_err=0, overrun=0.
  - Clear mid-frame abandons the frame; no partial word is ever presented.
- State encoding: IDLE, SHIFT, PARITY, HOLD.
  - po_valid, busy and shift_en are decoded from the state register only (no combinational path from inputs).
- IDLE:
  - start=1 at edge E -> SHIFT, bit_cnt=0.
  - si at edge E is NOT captured.
- SHIFT:
  - shift_en=1. At each edge: sreg <= {sreg[WIDTH-2:0], si}, bit_cnt++.
  - At the edge capturing bit WIDTH-1: go to PARITY if PARITY_EN=1, else HOLD.
  - Data bits are therefore sampled at edges E+1 .. E+WIDTH.
  - start is ignored in SHIFT.
- PARITY:
  - Lasts one cycle; shift_en=0; si sampled at edge E+WIDTH+1.
  - parity_err <= (^sreg) ^ si. Even parity: the XOR of data bits and the parity bit must be 0.
  - Next state is HOLD.
  - start is ignored in PARITY.
- HOLD:
  - po_valid=1. po and parity_err are held stable until the handshake completes.
  - po is registered from sreg on entry to HOLD.
  - Latency: po_valid is first high in the cycle after the last sampled bit (data bit, or parity bit when PARITY_EN=1).
  - po_ready=1 and start=0 -> IDLE; po_valid drops next cycle; po keeps its last value.
  - po_ready=1 and start=1 -> SHIFT directly (back-to-back frame; bit_cnt=0; same sampling timing as from IDLE).
  - po_ready=0 and start=1 -> start dropped, overrun=1 for one cycle (registered), state stays HOLD.
- po_ready outside HOLD has no effect.
- bit_cnt width is $clog2(WIDTH)+1. The counter never wraps within a frame; it resets to 0 on every frame start.
- Simultaneous clear and start: clear wins.

Test Plan:
1. Reset check: hold clear=1 while driving start=1, si=1 -> all outputs 0, state IDLE. Release clear -> still idle until the next start.
2. PARITY_EN=0, WIDTH=3: start pulse, then si=1,0,1 on the next 3 edges -> shift_en high for exactly 3 cycles; po_valid next cycle with po=3'b101, parity_err=0. po_ready=1 -> po_valid low next cycle.
3. PARITY_EN=1: data 1,1,0 then parity bit 0 -> po=3'b110, parity_err=0. Repeat with parity bit 1 -> parity_err=1. po_valid appears 4 edges after start acceptance.
4. Backpressure/overrun: word 3'b011 held with po_ready=0 for 5 cycles; pulse start once -> po stays 3'b011, overrun high for 1 cycle, no new frame. Then po_ready=1 -> IDLE.
5. Back-to-back: in HOLD, assert po_ready=1 and start=1 in the same cycle, then shift 0,1,0 -> first word consumed, busy high next cycle, second word po=3'b010 delivered with no idle gap.
6. Clear mid-frame: assert clear after 2 of 3 bits -> immediate return to IDLE, po_valid never asserts. A new start then yields a correct full word, e.g. 3'b111.
